// File: rtl/conv_sysarr_mul_drain.sv
// Drain stage behind the conv systolic-array multiplier: tracks operand tags, drives the multiplier
// clock enable, and accumulates products into per-group sums. Build option: CONVSYS_DRAIN_SAT_EN.
module conv_sysarr_mul_drain #(
  parameter int MUL_LAT = 3,
  parameter int P_W     = 11,
  parameter int ACC_W   = 24
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  input  logic                    in_last_i,
  output logic                    in_ready_o,
  output logic                    mul_ce_o,
  input  logic signed [P_W-1:0]   mul_dout_i,
  output logic signed [ACC_W-1:0] res_data_o,
  output logic [15:0]             res_cnt_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic                    res_ovf_o
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Operands of equal sign whose sum flips sign have left the representable range.
  function automatic logic add_ovf(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    add_ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  logic [MUL_LAT-1:0]      tag_v_q;
  logic [MUL_LAT-1:0]      tag_last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [15:0]             cnt_q;
  logic [15:0]             cnt_d;
  logic                    first_q;
  logic signed [ACC_W-1:0] res_data_q;
  logic [15:0]             res_cnt_q;
  logic                    res_valid_q;
  logic                    ovf_q;

  logic                    tail_v_s;
  logic                    tail_last_s;
  logic                    ce_s;
  logic                    take_s;
  logic                    fire_s;
  logic                    ovf_s;
  logic signed [ACC_W-1:0] ext_s;
  logic signed [ACC_W-1:0] sum_s;

  assign tail_v_s    = tag_v_q[MUL_LAT-1];
  assign tail_last_s = tag_last_q[MUL_LAT-1];
  // Only a completing product that cannot land in the held result slot freezes the pipe.
  assign ce_s        = !(tail_v_s && tail_last_s && res_valid_q && !res_ready_i);
  assign take_s      = ce_s && tail_v_s;
  assign fire_s      = take_s && tail_last_s;

  assign mul_ce_o    = ce_s;
  assign in_ready_o  = ce_s;
  assign res_data_o  = res_data_q;
  assign res_cnt_o   = res_cnt_q;
  assign res_valid_o = res_valid_q;
  assign res_ovf_o   = ovf_q;

  // Next accumulator and term count for the product at the pipe tail.
  always_comb begin
    ext_s = {{(ACC_W-P_W){mul_dout_i[P_W-1]}}, mul_dout_i};
    sum_s = acc_q + ext_s;
    ovf_s = 1'b0;
    if (first_q) begin
      acc_d = ext_s;
      cnt_d = 16'd1;
    end else begin
      ovf_s = add_ovf(acc_q, ext_s, sum_s);
`ifdef CONVSYS_DRAIN_SAT_EN
      if (ovf_s) begin
        acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum_s;
      end
`else
      acc_d = sum_s;
`endif
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end
  end

  // Tag pipe, accumulator and result slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_v_q     <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= 16'd0;
      first_q     <= 1'b1;
      res_data_q  <= '0;
      res_cnt_q   <= 16'd0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (ce_s) begin
        tag_v_q[0]    <= in_valid_i;
        tag_last_q[0] <= in_valid_i && in_last_i;
        for (int i = 1; i < MUL_LAT; i++) begin
          tag_v_q[i]    <= tag_v_q[i-1];
          tag_last_q[i] <= tag_last_q[i-1];
        end
      end
      if (take_s) begin
        if (tail_last_s) begin
          res_data_q <= acc_d;
          res_cnt_q  <= cnt_d;
          first_q    <= 1'b1;
        end else begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          first_q <= 1'b0;
        end
        if (ovf_s) begin
          ovf_q <= 1'b1;
        end
      end
      if (fire_s) begin
        res_valid_q <= 1'b1;
      end else if (res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_sysarr_mul_drain.sv
// Directed bench for conv_sysarr_mul_drain with a behavioural ce-gated 11x11->11 multiplier.
module tb_conv_sysarr_mul_drain;
  localparam int MUL_LAT = 3;
  localparam int P_W     = 11;
  localparam int ACC_W   = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, in_last, in_ready, mul_ce, res_valid, res_ready, res_ovf;
  logic signed [P_W-1:0]   din0, din1, mul_dout;
  logic signed [ACC_W-1:0] res_data;
  logic [15:0]             res_cnt;
  logic signed [P_W-1:0]   mpipe [MUL_LAT];

  int errors = 0;
  int checks = 0;

  conv_sysarr_mul_drain #(.MUL_LAT(MUL_LAT), .P_W(P_W), .ACC_W(ACC_W)) u_dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(in_ready), .mul_ce_o(mul_ce), .mul_dout_i(mul_dout),
    .res_data_o(res_data), .res_cnt_o(res_cnt), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .res_ovf_o(res_ovf)
  );

  // Unreset multiplier model: product truncated to P_W, advancing only on ce.
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= din0 * din1;
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[MUL_LAT-1];

  typedef struct {
    int n;
    int a0; int a1; int a2;
    int b0; int b1; int b2;
    int gap;
    int exp_data;
    int exp_cnt;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input int t, input int x0, input int x1, input int x2);
    return (t == 0) ? x0 : ((t == 1) ? x1 : x2);
  endfunction

  task automatic issue(input int a, input int b, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    din0     = P_W'(a);
    din1     = P_W'(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last operand's issue edge; returns edges counted until res_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!res_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_ovf_data;

    vecs[0] = '{3,    3,  -2,  7,   4,  5,  1,  0,     9, 3};
    vecs[1] = '{1,   40,   0,  0,  40,  0,  0,  0,  -448, 1};
    vecs[2] = '{3,    1,   1,  1,   1,  1,  1,  2,     3, 3};
    vecs[3] = '{2,   -5,   2,  0,   7,  2,  0,  1,   -31, 2};
    vecs[4] = '{2, -1024, -1,  0,   1,  1,  0,  0, -1025, 2};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_cnt", res_cnt, 0);
    check("rst_ovf", res_ovf, 0);
    check("rst_ce", mul_ce, 1);

    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < vecs[v].n; t++) begin
        issue(pick(t, vecs[v].a0, vecs[v].a1, vecs[v].a2),
              pick(t, vecs[v].b0, vecs[v].b1, vecs[v].b2), t == vecs[v].n - 1);
        if (t != vecs[v].n - 1) repeat (vecs[v].gap) @(posedge clk);
      end
      wait_result(lat);
      check($sformatf("v%0d_latency", v), lat, MUL_LAT + 1);
      check($sformatf("v%0d_data", v), res_data, vecs[v].exp_data);
      check($sformatf("v%0d_cnt", v), res_cnt, vecs[v].exp_cnt);
      check($sformatf("v%0d_ovf", v), res_ovf, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pulse_end", v), res_valid, 0);
    end

    // Back-to-back single-term groups against a blocked consumer.
    res_ready = 1'b0;
    issue(5, 5, 1'b1);
    issue(2, 3, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("hold_valid", res_valid, 1);
    check("hold_data", res_data, 25);
    check("hold_ce", mul_ce, 0);
    check("hold_ready", in_ready, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("hold_data_stable", res_data, 25);
    check("hold_ce_stable", mul_ce, 0);
    res_ready = 1'b1;
    #1;
    check("release_ce", mul_ce, 1);
    check("release_first", res_data, 25);
    @(posedge clk);
    #1;
    check("release_second_valid", res_valid, 1);
    check("release_second_data", res_data, 6);
    check("release_second_cnt", res_cnt, 1);
    @(posedge clk);
    #1;
    check("release_drain", res_valid, 0);

    // Reset with a held result and a half-built group.
    res_ready = 1'b0;
    issue(3, 3, 1'b1);
    issue(1, 1, 1'b0);
    issue(1, 1, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_data", res_data, 9);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ce", mul_ce, 1);
    check("mid_rst_cnt", res_cnt, 0);
    res_ready = 1'b1;
    issue(2, 2, 1'b1);
    wait_result(lat);
    check("post_rst_latency", lat, MUL_LAT + 1);
    check("post_rst_data", res_data, 4);
    check("post_rst_cnt", res_cnt, 1);

    // Accumulation beyond the ACC_W range.
`ifdef CONVSYS_DRAIN_SAT_EN
    exp_ovf_data = 2047;
`else
    exp_ovf_data = 3 * 1023 - 4096;
`endif
    check("pre_ovf_flag", res_ovf, 0);
    issue(1023, 1, 1'b0);
    issue(1023, 1, 1'b0);
    issue(1023, 1, 1'b1);
    wait_result(lat);
    check("ovf_data", res_data, exp_ovf_data);
    check("ovf_cnt", res_cnt, 3);
    check("ovf_flag", res_ovf, 1);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_sticky", res_ovf, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
